// File: rtl/aes_key_pkg.sv
// Shared AES-128 key-schedule types, constants and byte-level helpers
// (S-box, round constants, RotWord/SubWord).
package aes_key_pkg;

   localparam int NR_AES128 = 10;

   typedef logic [31:0]  word_t;
   typedef logic [127:0] key_t;

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [7:0] rcon(input logic [3:0] round);
      logic [7:0] rc;
      case (round)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic word_t rot_word(input word_t w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic word_t sub_word(input word_t w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

endpackage

// File: rtl/aes_key_unexpand_step.sv
// Combinational one-round key step: inverse schedule step, plus the forward
// step when AES_KEY_UNEXPAND_FWD_EN is defined. One shared SubWord (4 S-boxes).
module aes_key_unexpand_step
   import aes_key_pkg::*;
(
   input  key_t       key,
   input  logic [3:0] round,
`ifdef AES_KEY_UNEXPAND_FWD_EN
   input  logic       fwd,
`endif
   output key_t       nxt
);

   word_t      w0, w1, w2, w3;
   word_t      p1, p2, p3;
   word_t      sub_in, sub_out;
   logic [7:0] rc;

   assign {w0, w1, w2, w3} = key;
   assign p3 = w3 ^ w2;
   assign p2 = w2 ^ w1;
   assign p1 = w1 ^ w0;

   // Both directions feed the same SubWord; only its input word and rcon index differ.
   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      sub_in = rot_word(p3);
      rc     = rcon(round);
`ifdef AES_KEY_UNEXPAND_FWD_EN
      if (fwd) begin
         sub_in = rot_word(w3);
         rc     = rcon(round + 4'd1);
      end
`endif
   end

   assign sub_out = sub_word(sub_in);

`ifdef AES_KEY_UNEXPAND_FWD_EN
   word_t o0, o1, o2, o3;
   assign o0 = w0 ^ sub_out ^ {rc, 24'h0};
   assign o1 = w1 ^ o0;
   assign o2 = w2 ^ o1;
   assign o3 = w3 ^ o2;
   assign nxt = fwd ? {o0, o1, o2, o3} : {w0 ^ sub_out ^ {rc, 24'h0}, p1, p2, p3};
`else
   assign nxt = {w0 ^ sub_out ^ {rc, 24'h0}, p1, p2, p3};
`endif

endmodule

// File: rtl/aes_key_unexpand.sv
// AES-128 inverse key schedule: walks round keys 10 -> 0 over a valid/ready
// handshake. Define AES_KEY_UNEXPAND_FWD_EN to add a forward (0 -> 10) mode.
module aes_key_unexpand
   import aes_key_pkg::*;
#(
   parameter int NR = NR_AES128
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
`ifdef AES_KEY_UNEXPAND_FWD_EN
   input  logic       fwd,
`endif
   input  key_t       key_in,
   output key_t       key_out,
   output logic [3:0] round_out,
   output logic       key_valid,
   input  logic       key_ready,
   output logic       busy,
   output logic       done
);

   if (NR != NR_AES128) begin : g_nr_check
      $error("aes_key_unexpand supports only NR = 10 (AES-128)");
   end

   localparam logic [3:0] NR_W = 4'(NR);

   state_t     state;
   key_t       nxt_key;
   logic [3:0] last_round;
   logic       accept;

   assign accept = key_valid && key_ready;

`ifdef AES_KEY_UNEXPAND_FWD_EN
   logic fwd_q;
   assign last_round = fwd_q ? NR_W : 4'd0;

   aes_key_unexpand_step u_step (
      .key   (key_out),
      .round (round_out),
      .fwd   (fwd_q),
      .nxt   (nxt_key)
   );
`else
   assign last_round = 4'd0;

   aes_key_unexpand_step u_step (
      .key   (key_out),
      .round (round_out),
      .nxt   (nxt_key)
   );
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         key_out   <= '0;
         round_out <= '0;
         key_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
`ifdef AES_KEY_UNEXPAND_FWD_EN
         fwd_q     <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking default makes done a single-cycle pulse; later assignments win.
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  key_out   <= key_in;
                  key_valid <= 1'b1;
                  busy      <= 1'b1;
                  state     <= RUN;
`ifdef AES_KEY_UNEXPAND_FWD_EN
                  fwd_q     <= fwd;
                  round_out <= fwd ? 4'd0 : NR_W;
`else
                  round_out <= NR_W;
`endif
               end
            end
            RUN: begin
               if (accept) begin
                  if (round_out == last_round) begin
                     key_valid <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                     state     <= IDLE;
                  end else begin
                     key_out   <= nxt_key;
`ifdef AES_KEY_UNEXPAND_FWD_EN
                     round_out <= fwd_q ? round_out + 4'd1 : round_out - 4'd1;
`else
                     round_out <= round_out - 4'd1;
`endif
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
